// File: rtl/serial_master_port.sv
// Serial bus initiator: turns one parallel request into a control frame followed by a
// bit-serial write or read data phase qualified by valid/last and paced by ready.
module serial_master_port #(
   parameter  int ADDR_DEPTH = 2000,
   parameter  int SLAVES     = 3,
   parameter  int DATA_WIDTH = 8,
   parameter  int BURST_W    = 8,
   localparam int ADDR_W     = $clog2(ADDR_DEPTH),
   localparam int S_ID_W     = $clog2(SLAVES + 1)
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  start,
   input  logic                  rw,
   input  logic                  burst,
   input  logic [S_ID_W-1:0]     slave_id,
   input  logic [ADDR_W-1:0]     address,
   input  logic [BURST_W-1:0]    burst_len,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  din_valid,
   output logic                  din_ready,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  dout_valid,
   output logic                  busy,
   output logic                  done,
   output logic                  control,
   output logic                  wD,
   output logic                  valid,
   output logic                  last,
   input  logic                  rD,
   input  logic                  ready
);

   localparam int FRAME_W = 5 + S_ID_W + ADDR_W;
   localparam int FCNT_W  = $clog2(FRAME_W + 1);
   localparam int BIT_W   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
   localparam logic [FCNT_W-1:0] FRAME_END = FCNT_W'(FRAME_W);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CTRL,
      S_WRITE,
      S_READ,
      S_DONE
   } state_t;

   state_t                state;
   logic [FRAME_W-1:0]    frame_sr;
   logic [FCNT_W-1:0]     frame_cnt;
   logic [BIT_W-1:0]      bit_cnt;
   logic [BURST_W-1:0]    word_cnt;
   logic [BURST_W-1:0]    num_words;
   logic [DATA_WIDTH-1:0] shift_sr;
   logic                  rw_q;

   logic [FRAME_W-1:0]    frame_word;
   logic [BURST_W-1:0]    req_words;
   logic                  frame_end;
   logic                  word_end;
   logic [BURST_W-1:0]    next_idx;
   logic                  next_last;
   logic                  wr_need;
   logic                  din_take;

   assign frame_word = {3'b111, slave_id, rw, burst, address};
   assign req_words  = (burst && (burst_len != '0)) ? burst_len : BURST_W'(1);

   // next_idx is the index of the word that starts on this edge; a write loads a new
   // word either right after the frame, at a word boundary, or while waiting on din.
   always_comb begin
      frame_end = (state == S_CTRL) && (frame_cnt == FRAME_END);
      word_end  = valid && ready && (bit_cnt == BIT_LAST);
      next_idx  = word_cnt;
      if (frame_end) begin
         next_idx = '0;
      end else if (word_end) begin
         next_idx = word_cnt + BURST_W'(1);
      end
      next_last = (next_idx == (num_words - BURST_W'(1)));
      wr_need   = 1'b0;
      if (frame_end) begin
         wr_need = rw_q;
      end else if (state == S_WRITE) begin
         wr_need = !valid || (word_end && !last);
      end
      din_take = wr_need && din_valid;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= S_IDLE;
         frame_sr   <= '0;
         frame_cnt  <= '0;
         bit_cnt    <= '0;
         word_cnt   <= '0;
         num_words  <= '0;
         shift_sr   <= '0;
         rw_q       <= 1'b0;
         din_ready  <= 1'b0;
         dout       <= '0;
         dout_valid <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         control    <= 1'b0;
         wD         <= 1'b0;
         valid      <= 1'b0;
         last       <= 1'b0;
      end else begin
         din_ready  <= din_take;
         dout_valid <= 1'b0;
         done       <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  rw_q      <= rw;
                  num_words <= req_words;
                  control   <= frame_word[FRAME_W-1];
                  frame_sr  <= {frame_word[FRAME_W-2:0], 1'b0};
                  frame_cnt <= FCNT_W'(1);
                  word_cnt  <= '0;
                  bit_cnt   <= '0;
                  busy      <= 1'b1;
                  state     <= S_CTRL;
               end
            end

            S_CTRL: begin
               if (frame_end) begin
                  control  <= 1'b0;
                  word_cnt <= next_idx;
                  bit_cnt  <= '0;
                  if (rw_q) begin
                     state <= S_WRITE;
                     if (din_take) begin
                        wD       <= din[DATA_WIDTH-1];
                        shift_sr <= {din[DATA_WIDTH-2:0], 1'b0};
                        valid    <= 1'b1;
                        last     <= next_last;
                     end
                  end else begin
                     state <= S_READ;
                     valid <= 1'b1;
                     last  <= next_last;
                  end
               end else begin
                  control   <= frame_sr[FRAME_W-1];
                  frame_sr  <= {frame_sr[FRAME_W-2:0], 1'b0};
                  frame_cnt <= frame_cnt + FCNT_W'(1);
               end
            end

            S_WRITE: begin
               if (word_end) begin
                  bit_cnt <= '0;
                  if (last) begin
                     wD    <= 1'b0;
                     valid <= 1'b0;
                     last  <= 1'b0;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     word_cnt <= next_idx;
                     if (din_take) begin
                        wD       <= din[DATA_WIDTH-1];
                        shift_sr <= {din[DATA_WIDTH-2:0], 1'b0};
                        valid    <= 1'b1;
                        last     <= next_last;
                     end else begin
                        wD    <= 1'b0;
                        valid <= 1'b0;
                        last  <= 1'b0;
                     end
                  end
               end else if (valid && ready) begin
                  wD       <= shift_sr[DATA_WIDTH-1];
                  shift_sr <= {shift_sr[DATA_WIDTH-2:0], 1'b0};
                  bit_cnt  <= bit_cnt + BIT_W'(1);
               end else if (din_take) begin
                  wD       <= din[DATA_WIDTH-1];
                  shift_sr <= {din[DATA_WIDTH-2:0], 1'b0};
                  valid    <= 1'b1;
                  last     <= next_last;
               end
            end

            // Reads have no local back-pressure: each completed word is presented once.
            S_READ: begin
               if (valid && ready) begin
                  shift_sr <= {shift_sr[DATA_WIDTH-2:0], rD};
                  if (word_end) begin
                     bit_cnt    <= '0;
                     dout       <= {shift_sr[DATA_WIDTH-2:0], rD};
                     dout_valid <= 1'b1;
                     if (last) begin
                        valid <= 1'b0;
                        last  <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                     end else begin
                        word_cnt <= next_idx;
                        last     <= next_last;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + BIT_W'(1);
                  end
               end
            end

            S_DONE: begin
               state <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_master_port.sv
// Scoreboard bench for serial_master_port: a local feeder, a serial slave model and
// bit-level monitors run from one negedge-driven process.
module tb_serial_master_port;

   localparam int DW      = 8;
   localparam int ADDR_W  = 11;
   localparam int S_ID_W  = 2;
   localparam int BURST_W = 8;
   localparam int FRAME_W = 5 + S_ID_W + ADDR_W;

   logic               clk = 1'b0;
   logic               resetn;
   logic               start;
   logic               rw;
   logic               burst;
   logic [S_ID_W-1:0]  slave_id;
   logic [ADDR_W-1:0]  address;
   logic [BURST_W-1:0] burst_len;
   logic [DW-1:0]      din;
   logic               din_valid;
   logic               din_ready;
   logic [DW-1:0]      dout;
   logic               dout_valid;
   logic               busy;
   logic               done;
   logic               control;
   logic               wD;
   logic               valid;
   logic               last;
   logic               rD;
   logic               ready;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] feed_q[$];
   logic [DW-1:0] wr_q[$];
   logic [DW-1:0] slave_q[$];
   logic [DW-1:0] rd_q[$];

   bit            mode_read;
   int            cur_n;
   int            xfer_bits;
   int            word_bits;
   int            word_idx;
   int            words_done;
   int            din_ready_cnt;
   int            dout_cnt;
   int            done_cnt = 0;
   int            fed_count;
   int            sbit;
   bit            last_bad;
   logic [DW-1:0] cur_bits;
   int            stall_at = -1;
   int            stall_len = 0;
   int            stall_left = 0;
   logic [1:0]    held;
   int            starve_word = -1;
   int            starve_left = 0;

   always #5 clk = ~clk;

   serial_master_port dut (
      .clk        (clk),
      .resetn     (resetn),
      .start      (start),
      .rw         (rw),
      .burst      (burst),
      .slave_id   (slave_id),
      .address    (address),
      .burst_len  (burst_len),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .dout       (dout),
      .dout_valid (dout_valid),
      .busy       (busy),
      .done       (done),
      .control    (control),
      .wD         (wD),
      .valid      (valid),
      .last       (last),
      .rD         (rD),
      .ready      (ready)
   );

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic resetCounters();
      xfer_bits     = 0;
      word_bits     = 0;
      word_idx      = 0;
      words_done    = 0;
      din_ready_cnt = 0;
      dout_cnt      = 0;
      fed_count     = 0;
      sbit          = 0;
      last_bad      = 1'b0;
      cur_bits      = '0;
   endtask

   task automatic queueWord(input bit is_read, input logic [DW-1:0] w);
      if (is_read) begin
         slave_q.push_back(w);
         rd_q.push_back(w);
      end else begin
         feed_q.push_back(w);
         wr_q.push_back(w);
      end
   endtask

   // One bus cycle: observe outputs at the falling edge, then drive ready, din and rD
   // for the next rising edge and record the bit that edge will transfer.
   task automatic tick();
      @(negedge clk);
      if (resetn) begin
         if (dout_valid) begin
            if (rd_q.size() == 0) checkOutput("dout_extra", dout_valid, 0);
            else checkOutput("dout_word", dout, rd_q.pop_front());
            dout_cnt++;
         end
         if (done) begin
            done_cnt++;
            checkOutput("done_busy", busy, 0);
            checkOutput("done_bits", xfer_bits, DW * cur_n);
            checkOutput("done_din_ready", din_ready_cnt, mode_read ? 0 : cur_n);
            if (mode_read) checkOutput("done_dout_cnt", dout_cnt, cur_n);
         end
         if (din_ready) begin
            din_ready_cnt++;
            fed_count++;
            if (feed_q.size() > 0) feed_q.delete(0);
         end
         if (!busy) checkOutput("idle_lines", {control, valid, last, wD}, 0);
      end

      ready = 1'b1;
      if (stall_left > 0 && xfer_bits == stall_at) begin
         if (stall_left == stall_len) begin
            held = {valid, wD};
            checkOutput("stall_valid", valid, 1);
         end else begin
            checkOutput("stall_hold", {valid, wD}, held);
         end
         ready = 1'b0;
         stall_left--;
      end

      if (starve_left > 0 && fed_count == starve_word && words_done >= starve_word) begin
         checkOutput("starve_valid", valid, 0);
         starve_left--;
      end
      if (starve_left > 0 && fed_count == starve_word) begin
         din_valid = 1'b0;
      end else begin
         din_valid = (feed_q.size() > 0);
         din       = din_valid ? feed_q[0] : '0;
      end

      rD = 1'b0;
      if (mode_read && valid && ready && slave_q.size() > 0) begin
         rD = slave_q[0][DW-1-sbit];
         sbit++;
         if (sbit == DW) begin
            slave_q.delete(0);
            sbit = 0;
         end
      end

      if (resetn && valid && ready) begin
         xfer_bits++;
         if (!mode_read) cur_bits = {cur_bits[DW-2:0], wD};
         if (last !== (word_idx == cur_n - 1)) last_bad = 1'b1;
         word_bits++;
         if (word_bits == DW) begin
            if (!mode_read) begin
               if (wr_q.size() == 0) checkOutput("wr_extra", valid, 0);
               else checkOutput("wr_word", cur_bits, wr_q.pop_front());
            end
            checkOutput("last_flag", last_bad, 0);
            last_bad  = 1'b0;
            word_bits = 0;
            word_idx++;
            words_done++;
         end
      end
   endtask

   task automatic applyStimulus(input bit rw_i, input bit burst_i, input logic [S_ID_W-1:0] sid,
                                input logic [ADDR_W-1:0] addr, input logic [BURST_W-1:0] blen,
                                input bit inj_ctrl);
      logic [FRAME_W-1:0] exp_frame;
      exp_frame = {3'b111, sid, rw_i, burst_i, addr};
      cur_n     = burst_i ? ((blen == 0) ? 1 : int'(blen)) : 1;
      mode_read = !rw_i;
      resetCounters();
      tick();
      start     = 1'b1;
      rw        = rw_i;
      burst     = burst_i;
      slave_id  = sid;
      address   = addr;
      burst_len = blen;
      for (int i = 0; i < FRAME_W; i++) begin
         tick();
         start = 1'b0;
         checkOutput("ctrl_bit", control, exp_frame[FRAME_W-1-i]);
         if (inj_ctrl && i == 5) begin
            start = 1'b1;
            rw    = ~rw_i;
         end
      end
      tick();
      checkOutput("ctrl_end", control, 0);
   endtask

   task automatic waitDone(input bit inj_done);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 3000 && !seen; k++) begin
         tick();
         seen = done;
      end
      checkOutput("done_seen", seen, 1);
      if (inj_done && seen) begin
         start = 1'b1;
         tick();
         start = 1'b0;
      end
      checkOutput("wr_q_drained", wr_q.size(), 0);
      checkOutput("rd_q_drained", rd_q.size(), 0);
   endtask

   initial begin
      int d0;
      resetn    = 1'b0;
      start     = 1'b0;
      rw        = 1'b0;
      burst     = 1'b0;
      slave_id  = '0;
      address   = '0;
      burst_len = '0;
      din       = '0;
      din_valid = 1'b0;
      rD        = 1'b0;
      ready     = 1'b1;
      resetCounters();
      cur_n = 1;

      repeat (3) tick();
      checkOutput("reset_outputs",
                  {control, wD, valid, last, busy, done, din_ready, dout_valid, dout}, 0);
      resetn = 1'b1;
      repeat (2) tick();

      $display("[TB] single write");
      queueWord(0, 8'hA5);
      applyStimulus(1, 0, 2'd1, 11'd5, 8'd0, 0);
      waitDone(0);

      $display("[TB] burst write with stall, start during frame and done");
      d0 = done_cnt;
      queueWord(0, 8'h11);
      queueWord(0, 8'h22);
      queueWord(0, 8'h33);
      stall_at   = 12;
      stall_len  = 4;
      stall_left = 4;
      applyStimulus(1, 1, 2'd2, 11'd100, 8'd3, 1);
      waitDone(1);
      stall_left = 0;
      repeat (10) tick();
      checkOutput("one_done", done_cnt - d0, 1);
      checkOutput("idle_after_done", busy, 0);

      $display("[TB] burst read");
      queueWord(1, 8'h3C);
      queueWord(1, 8'hC3);
      applyStimulus(0, 1, 2'd3, 11'd1999, 8'd2, 0);
      waitDone(0);

      $display("[TB] din starvation");
      queueWord(0, 8'h5A);
      queueWord(0, 8'h96);
      queueWord(0, 8'hF0);
      starve_word = 1;
      starve_left = 5;
      applyStimulus(1, 1, 2'd0, 11'd42, 8'd3, 0);
      waitDone(0);
      checkOutput("starve_consumed", starve_left, 0);
      starve_left = 0;

      $display("[TB] reset mid-burst");
      queueWord(0, 8'h01);
      queueWord(0, 8'h02);
      queueWord(0, 8'h03);
      applyStimulus(1, 1, 2'd2, 11'd300, 8'd3, 0);
      for (int k = 0; k < 500 && xfer_bits < 10; k++) tick();
      checkOutput("reset_reach", xfer_bits >= 10, 1);
      d0 = done_cnt;
      #2 resetn = 1'b0;
      #1;
      checkOutput("midreset_outputs",
                  {control, wD, valid, last, busy, done, din_ready, dout_valid, dout}, 0);
      feed_q.delete();
      wr_q.delete();
      repeat (4) tick();
      resetn = 1'b1;
      repeat (4) tick();
      checkOutput("no_done_on_reset", done_cnt - d0, 0);

      $display("[TB] post-reset write, burst_len 0");
      queueWord(0, 8'h3E);
      applyStimulus(1, 1, 2'd0, 11'd2047, 8'd0, 0);
      waitDone(0);

      $display("[TB] single read ignores burst_len");
      queueWord(1, 8'h81);
      applyStimulus(0, 0, 2'd1, 11'd0, 8'd9, 0);
      waitDone(0);
      repeat (3) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
